decode: RTL and testbench

- Pipeline stage directly downstream of fetch in the pipelined CPU.
- Consumes fetch's registered pc and bubble flag, plus the instruction word from the synchronous instruction memory.
- Splits the instruction into fields, drives register-file read addresses, and detects load-use hazards.
- Registers a decoded bundle for execute.
- Holds the fetched instruction across stalls, because the memory output does not stay aligned with fetch's pc output while fetch is frozen.

---
 rtl/decode_pkg.sv | 40 ++++
 rtl/decode_imm_gen.sv | 25 ++
 rtl/decode.sv | 153 +++++++++++++++
 tb/tb_decode.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: widths, instruction field positions,
// opcode encoding and the per-opcode register-read usage helpers.
package decode_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 3;

  localparam int OP_LSB  = 13;
  localparam int OP_W    = 3;
  localparam int TGT_LSB = 10;
  localparam int SA_LSB  = 7;
  localparam int SB_LSB  = 0;
  localparam int IMM7_W  = 7;
  localparam int LUI_W   = 10;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_NAND = 3'd2,
    OP_LUI  = 3'd3,
    OP_SW   = 3'd4,
    OP_LW   = 3'd5,
    OP_BEQ  = 3'd6,
    OP_JALR = 3'd7
  } op_e;

  function automatic logic uses_a(input op_e op);
    return op != OP_LUI;
  endfunction

  function automatic logic uses_b(input op_e op);
    return (op == OP_ADD) || (op == OP_NAND) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  // Stores and branches compare/store the tgt register, so port B reads tgt.
  function automatic logic b_reads_tgt(input op_e op);
    return (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: sign-extended 7-bit immediate or lui upper immediate.
// Purely combinational; no flow control.
module imm_gen
  import decode_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  op_e               op,
  input  logic [LUI_W-1:0]  field,
  output logic [DATA_W-1:0] imm
);

  always_comb begin
    imm = '0;
    unique case (op)
      OP_ADDI, OP_SW, OP_LW, OP_BEQ:
        imm = {{(DATA_W-IMM7_W){field[IMM7_W-1]}}, field[IMM7_W-1:0]};
      OP_LUI:
        imm = {field, {(DATA_W-LUI_W){1'b0}}};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// Decode stage: splits the instruction, drives regfile read addresses, detects
// load-use hazards; one-cycle latency, holds the fetched word while stalled.
module decode
  import decode_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              bubble_in,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [REG_W-1:0]  ex_dest,
  input  logic              ex_is_load,
  output logic [REG_W-1:0]  rf_raddr_a,
  output logic [REG_W-1:0]  rf_raddr_b,
  output logic              stall_out,
  output logic [OP_W-1:0]   opcode_out,
  output logic [REG_W-1:0]  tgt_out,
  output logic [REG_W-1:0]  src_a_out,
  output logic [REG_W-1:0]  src_b_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] pc_out,
  output logic              bubble_out
);

  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_inst_q, hold_inst_d;
  logic              hold_bubble_q, hold_bubble_d;

  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [REG_W-1:0]  tgt_q, tgt_d;
  logic [REG_W-1:0]  src_a_q, src_a_d;
  logic [REG_W-1:0]  src_b_q, src_b_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              bubble_q, bubble_d;

  logic [DATA_W-1:0] cur_inst;
  logic              cur_bubble;
  op_e               cur_op;
  logic [REG_W-1:0]  cur_tgt, cur_sa, cur_sb, cur_rb;
  logic [DATA_W-1:0] cur_imm;
  logic              hit_a, hit_b, hazard;

  // While stalled the imem output drifts away from pc_in, so the held copy wins.
  always_comb begin
    cur_inst   = hold_valid_q ? hold_inst_q : mem_data;
    cur_bubble = hold_valid_q ? hold_bubble_q : bubble_in;
    cur_op     = op_e'(cur_inst[OP_LSB +: OP_W]);
    cur_tgt    = cur_inst[TGT_LSB +: REG_W];
    cur_sa     = cur_inst[SA_LSB +: REG_W];
    cur_sb     = cur_inst[SB_LSB +: REG_W];
    cur_rb     = b_reads_tgt(cur_op) ? cur_tgt : cur_sb;
  end

  imm_gen #(
    .DATA_W (DATA_W)
  ) u_imm_gen (
    .op    (cur_op),
    .field (cur_inst[LUI_W-1:0]),
    .imm   (cur_imm)
  );

  always_comb begin
    hit_a  = uses_a(cur_op) && (ex_dest == cur_sa);
    hit_b  = uses_b(cur_op) && (ex_dest == cur_rb);
    hazard = !cur_bubble && ex_is_load && (ex_dest != '0) && (hit_a || hit_b);
  end

  assign rf_raddr_a = cur_sa;
  assign rf_raddr_b = cur_rb;
  assign stall_out  = stall | hazard;

  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_inst_d   = hold_inst_q;
    hold_bubble_d = hold_bubble_q;
    opcode_d      = opcode_q;
    tgt_d         = tgt_q;
    src_a_d       = src_a_q;
    src_b_d       = src_b_q;
    imm_d         = imm_q;
    pc_d          = pc_q;
    bubble_d      = bubble_q;

    if (stall) begin
      if (!hold_valid_q) begin
        hold_valid_d  = 1'b1;
        hold_inst_d   = mem_data;
        hold_bubble_d = bubble_in;
      end
    end else if (flush) begin
      bubble_d     = 1'b1;
      hold_valid_d = 1'b0;
    end else if (hazard) begin
      // Insert a no-op and keep the hazarding instruction parked in the hold.
      bubble_d = 1'b1;
      if (!hold_valid_q) begin
        hold_valid_d  = 1'b1;
        hold_inst_d   = mem_data;
        hold_bubble_d = bubble_in;
      end
    end else begin
      opcode_d     = cur_op;
      tgt_d        = cur_tgt;
      src_a_d      = cur_sa;
      src_b_d      = cur_sb;
      imm_d        = cur_imm;
      pc_d         = pc_in;
      bubble_d     = cur_bubble;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q  <= 1'b0;
      hold_inst_q   <= '0;
      hold_bubble_q <= 1'b0;
      opcode_q      <= '0;
      tgt_q         <= '0;
      src_a_q       <= '0;
      src_b_q       <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      bubble_q      <= 1'b1;
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_inst_q   <= hold_inst_d;
      hold_bubble_q <= hold_bubble_d;
      opcode_q      <= opcode_d;
      tgt_q         <= tgt_d;
      src_a_q       <= src_a_d;
      src_b_q       <= src_b_d;
      imm_q         <= imm_d;
      pc_q          <= pc_d;
      bubble_q      <= bubble_d;
    end
  end

  assign opcode_out = opcode_q;
  assign tgt_out    = tgt_q;
  assign src_a_out  = src_a_q;
  assign src_b_out  = src_b_q;
  assign imm_out    = imm_q;
  assign pc_out     = pc_q;
  assign bubble_out = bubble_q;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage with hand-computed expectations.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst, stall, flush, bubble_in, ex_is_load;
  logic [15:0] pc_in, mem_data;
  logic [2:0]  ex_dest;
  logic [2:0]  rf_raddr_a, rf_raddr_b, opcode_out, tgt_out, src_a_out, src_b_out;
  logic        stall_out, bubble_out;
  logic [15:0] imm_out, pc_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .pc_in      (pc_in),
    .bubble_in  (bubble_in),
    .mem_data   (mem_data),
    .ex_dest    (ex_dest),
    .ex_is_load (ex_is_load),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .stall_out  (stall_out),
    .opcode_out (opcode_out),
    .tgt_out    (tgt_out),
    .src_a_out  (src_a_out),
    .src_b_out  (src_b_out),
    .imm_out    (imm_out),
    .pc_out     (pc_out),
    .bubble_out (bubble_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; bubble_in = 1'b0;
    ex_is_load = 1'b0; ex_dest = 3'd0; pc_in = 16'h0; mem_data = 16'h0;
    tick(); tick();
    chk("rst_bubble", 16'(bubble_out), 16'd1);
    chk("rst_opcode", 16'(opcode_out), 16'd0);
    chk("rst_pc", pc_out, 16'h0);
    chk("rst_imm", imm_out, 16'h0);

    // addi r1,r1,3
    rst = 1'b0; mem_data = 16'h2483; pc_in = 16'h0000;
    settle();
    chk("addi_stall", 16'(stall_out), 16'd0);
    chk("addi_ra", 16'(rf_raddr_a), 16'd1);
    chk("addi_rb", 16'(rf_raddr_b), 16'd3);
    tick();
    chk("addi_op", 16'(opcode_out), 16'd1);
    chk("addi_tgt", 16'(tgt_out), 16'd1);
    chk("addi_sa", 16'(src_a_out), 16'd1);
    chk("addi_imm", imm_out, 16'h0003);
    chk("addi_bub", 16'(bubble_out), 16'd0);
    chk("addi_pc", pc_out, 16'h0000);

    // add r3,r2,r4 behind lw r2
    mem_data = 16'h0D04; pc_in = 16'h0002; ex_is_load = 1'b1; ex_dest = 3'd2;
    settle();
    chk("lu_stall", 16'(stall_out), 16'd1);
    tick();
    chk("lu_bub", 16'(bubble_out), 16'd1);
    chk("lu_pc_keep", pc_out, 16'h0000);
    mem_data = 16'hFFFF;
    settle();
    chk("lu_stall_held", 16'(stall_out), 16'd1);
    chk("lu_ra_held", 16'(rf_raddr_a), 16'd2);
    tick();
    chk("lu_bub2", 16'(bubble_out), 16'd1);
    ex_is_load = 1'b0;
    settle();
    chk("lu_release", 16'(stall_out), 16'd0);
    tick();
    chk("lu_op", 16'(opcode_out), 16'd0);
    chk("lu_tgt", 16'(tgt_out), 16'd3);
    chk("lu_sa", 16'(src_a_out), 16'd2);
    chk("lu_sb", 16'(src_b_out), 16'd4);
    chk("lu_pc", pc_out, 16'h0002);
    chk("lu_bub3", 16'(bubble_out), 16'd0);

    // external stall for three cycles with drifting imem data
    stall = 1'b1; mem_data = 16'h2483; pc_in = 16'h0004;
    settle();
    chk("st_stall_out", 16'(stall_out), 16'd1);
    tick();
    mem_data = 16'h77FF; tick();
    mem_data = 16'hC8FF; tick();
    chk("st_frozen_op", 16'(opcode_out), 16'd0);
    chk("st_frozen_pc", pc_out, 16'h0002);
    stall = 1'b0; mem_data = 16'hA7C0;
    settle();
    chk("st_release", 16'(stall_out), 16'd0);
    tick();
    chk("st_op", 16'(opcode_out), 16'd1);
    chk("st_imm", imm_out, 16'h0003);
    chk("st_pc", pc_out, 16'h0004);

    // lui r5,0x3FF
    mem_data = 16'h77FF; pc_in = 16'h0006;
    tick();
    chk("lui_op", 16'(opcode_out), 16'd3);
    chk("lui_tgt", 16'(tgt_out), 16'd5);
    chk("lui_imm", imm_out, 16'hFFC0);

    // beq r1,r2,-1
    mem_data = 16'hC8FF; pc_in = 16'h0008;
    settle();
    chk("beq_ra", 16'(rf_raddr_a), 16'd1);
    chk("beq_rb_tgt", 16'(rf_raddr_b), 16'd2);
    tick();
    chk("beq_op", 16'(opcode_out), 16'd6);
    chk("beq_imm", imm_out, 16'hFFFF);

    // flush of a valid instruction
    mem_data = 16'h2483; pc_in = 16'h000A; flush = 1'b1;
    tick();
    chk("fl_bub", 16'(bubble_out), 16'd1);
    flush = 1'b0; mem_data = 16'hA7C0; pc_in = 16'h000C;
    tick();
    chk("fl_next_op", 16'(opcode_out), 16'd5);
    chk("fl_next_imm", imm_out, 16'hFFC0);
    chk("fl_next_pc", pc_out, 16'h000C);
    chk("fl_next_bub", 16'(bubble_out), 16'd0);

    // sw r4,r1,5: port B reads tgt, which feeds the hazard check
    mem_data = 16'h9085; pc_in = 16'h000E; ex_is_load = 1'b1; ex_dest = 3'd4;
    settle();
    chk("sw_rb_tgt", 16'(rf_raddr_b), 16'd4);
    chk("sw_haz", 16'(stall_out), 16'd1);
    ex_is_load = 1'b0;
    settle();
    chk("sw_nohaz", 16'(stall_out), 16'd0);
    tick();
    chk("sw_op", 16'(opcode_out), 16'd4);
    chk("sw_imm", imm_out, 16'h0005);

    // flush while the hazarding instruction is already held
    mem_data = 16'h0D04; pc_in = 16'h0010; ex_is_load = 1'b1; ex_dest = 3'd2;
    tick();
    flush = 1'b1; mem_data = 16'hFFFF;
    settle();
    chk("fh_stall", 16'(stall_out), 16'd1);
    tick();
    chk("fh_bub", 16'(bubble_out), 16'd1);
    flush = 1'b0; mem_data = 16'h2483;
    settle();
    chk("fh_released", 16'(stall_out), 16'd0);
    tick();
    chk("fh_op", 16'(opcode_out), 16'd1);
    chk("fh_pc", pc_out, 16'h0010);

    // r0 destination never hazards
    mem_data = 16'h0C00; pc_in = 16'h0012; ex_dest = 3'd0;
    settle();
    chk("r0_stall", 16'(stall_out), 16'd0);
    tick();
    chk("r0_bub", 16'(bubble_out), 16'd0);
    chk("r0_tgt", 16'(tgt_out), 16'd3);

    // bubble from fetch never hazards and passes through
    mem_data = 16'h0D04; pc_in = 16'h0014; ex_dest = 3'd2; bubble_in = 1'b1;
    settle();
    chk("bb_stall", 16'(stall_out), 16'd0);
    tick();
    chk("bb_bub", 16'(bubble_out), 16'd1);

    // lui reads nothing even when its sa/sb fields equal ex_dest
    bubble_in = 1'b0; mem_data = 16'h77FF; pc_in = 16'h0016; ex_dest = 3'd7;
    settle();
    chk("lui_nohaz", 16'(stall_out), 16'd0);
    tick();
    chk("lui2_bub", 16'(bubble_out), 16'd0);
    ex_is_load = 1'b0;

    // reset in the middle of a stall drops the held instruction
    stall = 1'b1; mem_data = 16'h2483; pc_in = 16'h0018;
    tick();
    mem_data = 16'h77FF; rst = 1'b1;
    tick();
    chk("rs_bub", 16'(bubble_out), 16'd1);
    chk("rs_pc", pc_out, 16'h0000);
    rst = 1'b0; stall = 1'b0; mem_data = 16'hA7C0; pc_in = 16'h001A;
    settle();
    chk("rs_stall", 16'(stall_out), 16'd0);
    tick();
    chk("rs_op", 16'(opcode_out), 16'd5);
    chk("rs_pc2", pc_out, 16'h001A);
    chk("rs_bub2", 16'(bubble_out), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
